serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle ripple-borrow subtractor computing `diff = a - b - bin` over WIDTH-bit unsigned/two's-complement operands, DIGIT bits per clock. It is the subtraction counterpart to the adder chain in the arithmetic library. It sits between a valid/ready producer and a valid/ready consumer, trading latency for a DIGIT-wide datapath. It accepts one operation at a time and holds the result until the consumer takes it.

## Interface
- WIDTH, 8, operand/result width; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; N = WIDTH/DIGIT RUN cycles per operation.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer presents a, b and bin.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  diff, bout and ovf are valid.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow out: 1 iff a < b + bin.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b and bin into the operand shift registers and the borrow register. Clear the digit counter. Go to RUN.
- RUN (exactly N cycles):
  - Each cycle, subtract the low DIGIT bits of the operand registers using the borrow register.
  - Shift the DIGIT-bit result into the top of the diff register.
  - Shift the operands right by DIGIT and update the borrow register with the digit's borrow out.
  - After the Nth cycle: load bout from the final borrow, compute ovf from the latched operand MSBs and the final diff MSB, and go to DONE.
- DONE:
  - out_valid = 1; diff, bout and ovf are held stable.
  - On out_valid & out_ready, go to IDLE. Results stay on the outputs until the next completion; they are not cleared.
- in_ready is decoded from state and is 1 only in IDLE. in_valid is ignored in RUN and DONE.
- out_valid is decoded from state and is 1 only in DONE.
- Arithmetic is a pure ripple-borrow chain across digits. Carry/borrow between digits passes only through the borrow register.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1 and out_valid = 0.
  - diff = 0, bout = 0, ovf = 0, borrow register = 0, counter = 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately and asynchronously. No result is delivered.
- Latency:
  - Accepting edge is edge 0.
  - out_valid rises after edge N (2 cycles for the defaults).
  - Minimum initiation interval is N + 2 cycles: accept, N RUN cycles, DONE with immediate out_ready, then back to IDLE.
- Simultaneous events:
  - An output handshake in DONE together with in_valid does not accept the new operation; it is accepted on the next IDLE cycle.
  - An out_ready pulse outside DONE has no effect.
- Backpressure: DONE holds indefinitely while out_ready = 0, with all outputs stable.
- in_valid dropping before acceptance is legal; nothing is latched.
- Boundary conditions:
  - bin = 1 with a = b gives diff = all ones and bout = 1.
  - The counter wraps to 0 on RUN exit.

## Structure
- Package `sub_pkg`:
  - state enum typedef `sub_state_t` (IDLE, RUN, DONE).
  - elaboration check that WIDTH % DIGIT == 0.
- Sub-module `full_subtractor`:
  - ports a, b, bi, d, bo.
  - d = a^b^bi.
  - bo = (~a&b) | (~a&bi) | (b&bi).
  - DIGIT instances are chained by generate to form the per-cycle digit datapath.

## Test plan
Defaults: WIDTH = 8, DIGIT = 4.
- a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0, ovf=0; out_valid exactly 2 cycles after the accept edge.
- a=0x10, b=0x0F, bin=1 (borrow crosses the nibble boundary) -> diff=0x00, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Also a=0x55, b=0x55, bin=1 -> diff=0xFF, bout=1.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid, diff, bout and ovf stay stable; in_ready=0; the new operation is accepted one cycle after the output handshake.
- Assert rst_n=0 during the first RUN cycle -> out_valid=0, in_ready=1 and diff=0 immediately. The next operation 0x35-0x12 then returns 0x23.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 4;

  // True when the operand width splits into a whole number of digits.
  function automatic bit digit_fits(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, bo is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per clock.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid must not depend on ready; ready is decoded from state only
// (in_ready only in IDLE, out_valid only in DONE).
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!digit_fits(WIDTH, DIGIT)) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  sub_state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, diff_sh, diff_sh_next;
  logic [WIDTH-1:0] dig_ext;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             last_digit;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q;

  logic [DIGIT-1:0] dig_d;
  logic [DIGIT:0]   dig_chain;

  // Per-cycle digit datapath: DIGIT full subtractors rippling the borrow.
  assign dig_chain[0] = brw;
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_digit
      full_subtractor u_fs (
        .a  (a_sh[i]),
        .b  (b_sh[i]),
        .bi (dig_chain[i]),
        .d  (dig_d[i]),
        .bo (dig_chain[i+1])
      );
    end
  endgenerate

  assign dig_ext      = WIDTH'(dig_d) << (WIDTH - DIGIT);
  assign diff_sh_next = (diff_sh >> DIGIT) | dig_ext;
  assign last_digit   = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; ready/valid are pure functions of state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifting, borrow ripple and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          brw     <= dig_chain[DIGIT];
          diff_sh <= diff_sh_next;
          if (last_digit) begin
            // Results land in separate registers so they stay put until the
            // next completion, regardless of later shifting.
            cnt    <= '0;
            diff_q <= diff_sh_next;
            bout_q <= dig_chain[DIGIT];
            ovf_q  <= (a_msb ^ b_msb) & (dig_d[DIGIT-1] ^ a_msb);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8, DIGIT=4).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected results: {diff, bout, ovf}.
  logic [9:0] exp_q[$];

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare the held result against the oldest expected entry.
  task automatic check_result(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_diff"}, {24'd0, diff}, {24'd0, e[9:2]});
      check({tag, "_bout"}, {31'd0, bout}, {31'd0, e[1]});
      check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e[0]});
    end
  endtask

  // Present an operation and wait for its acceptance edge.
  task automatic drive_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
    int g;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from acceptance to out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!out_valid && lat < 20);
    if (!out_valid) check("done_timeout", 0, 1);
  endtask

  task automatic handshake_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb,
                        input logic eo);
    int lat;
    exp_q.push_back({ed, eb, eo});
    drive_op(ta, tb_v, tbin);
    wait_done(lat);
    check({tag, "_latency"}, lat, 2);
    check_result(tag);
    handshake_out();
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_diff",      {24'd0, diff},      0);
    check("rst_bout",      {31'd0, bout},      0);
    check("rst_ovf",       {31'd0, ovf},       0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready pulse in IDLE does nothing.
    handshake_out();
    check("stray_out_ready", {31'd0, in_ready}, 1);

    run_op("basic",     8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
    run_op("nib_borrow",8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("eq_bin",    8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("ovf_neg",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_pos",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ff_bin",    8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Backpressure with a new operation waiting.
    exp_q.push_back({8'h23, 1'b0, 1'b0});
    drive_op(8'h35, 8'h12, 1'b0);
    wait_done(lat);
    check("bp_latency", lat, 2);
    @(negedge clk);
    a = 8'hA0; b = 8'h05; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_in_ready",  {31'd0, in_ready},  0);
      check("bp_diff",      {24'd0, diff},      32'h23);
    end
    check_result("bp");
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_not_accepted", {31'd0, in_ready}, 1);
    check("bp_valid_drop",   {31'd0, out_valid}, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_accepted_next", {31'd0, in_ready}, 0);
    exp_q.push_back({8'h9B, 1'b0, 1'b0});
    wait_done(lat);
    check("bp2_latency", lat, 2);
    check_result("bp2");
    handshake_out();

    // Reset during the first RUN cycle aborts the operation.
    drive_op(8'h35, 8'h12, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 0);
    check("abort_in_ready",  {31'd0, in_ready},  1);
    check("abort_diff",      {24'd0, diff},      0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
